// File: rtl/cam_pkg.sv
// Shared definitions for the CAM match-vector reader: default geometry,
// address-width helper and the reader's state encoding.
package cam_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Index width for a vector of `depth` entries; a single-entry CAM still needs one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage : cam_pkg

// File: rtl/cam_prio_enc.sv
// Combinational lowest-set-bit priority encoder over a CAM match vector.
// Also reports whether any bit is set and whether exactly one bit is set.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic [DEPTH-1:0]  vec_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              any_o,
  output logic              one_left_o
);

  logic [DEPTH-1:0] rest;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    idx_o = '0;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = ADDR_W'(i);
      end
    end
  end

  always_comb begin
    rest       = vec_i & (vec_i - DEPTH'(1));
    any_o      = |vec_i;
    one_left_o = any_o && (rest == '0);
  end

endmodule : cam_prio_enc

// File: rtl/cam_match_reader.sv
// Accepts one CAM match vector at a time and streams out every matching
// index in ascending order, with the vector's popcount and key echoed.
module cam_match_reader
  import cam_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEPTH-1:0]  in_match,
  input  logic [WIDTH-1:0]  in_key,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_last,
  output logic [ADDR_W:0]   res_count,
  output logic [WIDTH-1:0]  res_key
);

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  vec_q, vec_d;
  logic [WIDTH-1:0]  key_q, key_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [ADDR_W-1:0] low_idx;
  logic              low_any;
  logic              low_one_left;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  cam_prio_enc #(
    .DEPTH (DEPTH)
  ) u_prio_enc (
    .vec_i      (vec_q),
    .idx_o      (low_idx),
    .any_o      (low_any),
    .one_left_o (low_one_left)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    key_d     = key_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    res_hit   = 1'b0;
    res_addr  = '0;
    res_last  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vec_d   = in_match;
          key_d   = in_key;
          count_d = popcount(in_match);
          state_d = EMIT;
        end
      end

      EMIT: begin
        res_valid = 1'b1;
        res_hit   = low_any;
        res_addr  = low_any ? low_idx : '0;
        // An empty vector still yields exactly one (miss) result.
        res_last  = !low_any || low_one_left;
        if (res_ready) begin
          vec_d = vec_q & (vec_q - DEPTH'(1));
          if (res_last) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      key_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      key_q   <= key_d;
      count_q <= count_d;
    end
  end

  assign res_count = count_q;
  assign res_key   = key_q;

endmodule : cam_match_reader

// File: tb/tb_cam_match_reader.sv
// Randomized self-checking bench for cam_match_reader: each vector's expected
// result stream is derived from its set bits and compared result by result.
module tb_cam_match_reader;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DEPTH-1:0]  in_match;
  logic [WIDTH-1:0]  in_key;
  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic [ADDR_W-1:0] res_addr;
  logic              res_last;
  logic [ADDR_W:0]   res_count;
  logic [WIDTH-1:0]  res_key;

  int checks_total  = 0;
  int checks_passed = 0;

  cam_match_reader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_match  (in_match),
    .in_key    (in_key),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hit   (res_hit),
    .res_addr  (res_addr),
    .res_last  (res_last),
    .res_count (res_count),
    .res_key   (res_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  // Presents one vector, then walks the expected results at negedges.
  // stall_first >= 0 forces that many stall cycles on the first result.
  task automatic run_vector(input logic [DEPTH-1:0] vec, input logic [WIDTH-1:0] key,
                            input int max_stall, input int stall_first, input string tag);
    int addrs[$];
    int n;
    int stall;
    logic exp_hit;
    logic [31:0] exp_addr;
    logic exp_last;
    for (int i = 0; i < DEPTH; i++) if (vec[i]) addrs.push_back(i);
    n = (addrs.size() == 0) ? 1 : addrs.size();

    @(negedge clk);
    check_idle({tag, "_pre"});
    in_valid  = 1'b1;
    in_match  = vec;
    in_key    = key;
    res_ready = 1'b0;
    @(negedge clk);

    for (int r = 0; r < n; r++) begin
      stall    = (r == 0 && stall_first >= 0) ? stall_first : int'($urandom_range(0, max_stall));
      exp_hit  = (addrs.size() != 0);
      exp_addr = exp_hit ? 32'(addrs[r]) : 32'd0;
      exp_last = (r == n - 1);
      for (int s = 0; s <= stall; s++) begin
        check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_hit"}, 32'(res_hit), 32'(exp_hit));
        check({tag, "_addr"}, 32'(res_addr), exp_addr);
        check({tag, "_last"}, 32'(res_last), 32'(exp_last));
        check({tag, "_count"}, 32'(res_count), 32'(addrs.size()));
        check({tag, "_key"}, 32'(res_key), 32'(key));
        // Traffic on the input side must be ignored while busy.
        in_valid  = 1'($urandom_range(0, 1));
        in_match  = DEPTH'($urandom);
        in_key    = WIDTH'($urandom);
        res_ready = (s == stall);
        if (r == n - 1 && s == stall) in_valid = 1'b0;
        @(negedge clk);
      end
    end
    res_ready = 1'b0;
    in_valid  = 1'b0;
    check_idle({tag, "_post"});
  endtask

  function automatic logic [DEPTH-1:0] rand_vector();
    logic [DEPTH-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = DEPTH'(1) << $urandom_range(0, DEPTH - 1);
      3:       v = DEPTH'($urandom & $urandom & $urandom);
      default: v = DEPTH'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_match  = '0;
    in_key    = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    check("reset_hit", 32'(res_hit), 32'd0);
    check("reset_addr", 32'(res_addr), 32'd0);
    check("reset_last", 32'(res_last), 32'd0);
    check("reset_count", 32'(res_count), 32'd0);
    check("reset_key", 32'(res_key), 32'd0);

    run_vector(16'h0000, 8'hAA, 0, 0, "zero");
    run_vector(16'h0005, 8'h3F, 0, 0, "v0005");
    run_vector(16'h8000, 8'h11, 0, 0, "v8000");
    run_vector(16'hFFFF, 8'h77, 0, 0, "full");
    run_vector(16'h0090, 8'hC3, 0, 5, "stall");

    // Reset in the middle of a vector abandons the remaining results.
    @(negedge clk);
    in_valid = 1'b1;
    in_match = 16'h00F0;
    in_key   = 8'h5C;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstmid_first_addr", 32'(res_addr), 32'd4);
    res_ready = 1'b1;
    @(negedge clk);
    check("rstmid_second_addr", 32'(res_addr), 32'd5);
    res_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rstmid");
    check("rstmid_count", 32'(res_count), 32'd0);
    check("rstmid_key", 32'(res_key), 32'd0);
    run_vector(16'h0002, 8'h42, 0, 0, "after_rst");

    for (int t = 0; t < 40; t++) begin
      run_vector(rand_vector(), WIDTH'($urandom), 3, -1, "rand");
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule : tb_cam_match_reader
